fp_div_arbiter: RTL and testbench
=================================

// Module: fp_div_arbiter
// PURPOSE
//  Shares one multi-cycle fp_div unit among NREQ requesters. Round-robin arbitration over
//  valid/ready request channels; latches operands, restarts and sequences the divider, waits
//  for done, returns the tagged result and flags on a single response channel. Sits between
//  the FPU issue logic and the divider instance.
// PARAMETERS
//  W        32  operand/result width (IEEE-754 single)
//  NREQ     4   number of requesters (>=2)
//  IDW      2   requester id width, clog2(NREQ)
//  MIN_WAIT 2   RUN cycles during which div_done is ignored (covers divider output regs)
//  TMO      64  RUN-cycle timeout limit (only with DIV_TIMEOUT_EN)
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset, asynchronous, active-high
//  req_valid   in   NREQ     request valid, one bit per requester
//  req_ready   out  NREQ     request accepted (at most one bit set)
//  req_a       in   NREQ*W   dividends, requester i at [i*W +: W]
//  req_b       in   NREQ*W   divisors
//  req_rm      in   NREQ*3   rounding modes (RNe/RZ/RU/RD/RNa encodings)
//  rsp_valid   out  1        result valid
//  rsp_ready   in   1        result consumed
//  rsp_id      out  IDW      index of requester owning the result
//  rsp_data    out  W        quotient
//  rsp_flags   out  5        {ov,un,inv,div_zero,inexact}
//  div_in1/in2 out  W        divider operands, held from registers
//  div_round_m out  3        divider rounding mode
//  div_act     out  1        divider active
//  div_rst_n   out  1        divider reset, active-low
//  div_out     in   W        divider result
//  div_done    in   1        divider done
//  div_flags   in   5        divider {ov,un,inv,div_zero,inexact}
//  busy        out  1        state != IDLE
//  tmo_err     out  1        sticky timeout indicator
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, operand/result regs 0, rsp_valid 0, req_ready 0,
//   div_act 0, tmo_err 0, busy 0; div_rst_n = 0 while rst is high.
//  FSM IDLE -> CLR -> RUN -> RESP -> IDLE.
//  IDLE: grant = first set req_valid bit at or after pointer (wrapping); req_ready[grant]=1
//   combinationally. On handshake: latch a,b,rm,id; pointer <= (grant+1) mod NREQ; go CLR.
//   No valid bits: stay, pointer unchanged.
//  CLR: div_rst_n=0 for exactly one cycle (clears stale done); wait counter <= 0; go RUN.
//  RUN: div_act=1; counter increments. When counter>=MIN_WAIT and div_done=1: capture
//   div_out, div_flags into result regs; go RESP. div_done before MIN_WAIT is ignored.
//  RESP: rsp_valid=1, rsp_id/data/flags stable until rsp_ready; on rsp_ready go IDLE.
//   No new request is accepted in the handshake cycle; earliest next grant is next cycle.
//  req_ready all 0 outside IDLE; div_in1/in2/round_m constant from CLR through RESP.
//  Request dropped before grant: ignored, no state change. rsp_ready outside RESP: ignored.
//  Reset mid-operation: in-flight request discarded, no response issued, divider reset.
//  Min latency handshake->rsp_valid: 1 (CLR) + MIN_WAIT + 1 cycles.
// CONFIGURATION
//  DIV_TIMEOUT_EN defined: if RUN reaches TMO cycles without accepted done, go RESP with
//   rsp_data=32'h7FC00000, rsp_flags=5'b00100 (inv), set tmo_err (sticky until rst).
//  Not defined: RUN waits indefinitely; counter saturates at MIN_WAIT; tmo_err tied 0.
// STRUCTURE
//  Shared package fpu_pkg: round-mode encodings, FP_NANQ/FP_INF/FP_ZERO constants,
//   flag-vector bit indices, state encoding typedef.
//  Sub-module rr_arbiter (NREQ-bit rotating-priority grant; pointer held in parent).
// TESTING
//  1 req0 a=3F800000 b=40000000 rm=RNe -> rsp_id=0, rsp_data=3F000000, flags=00000.
//  2 all 4 req_valid held high, rsp_ready=1 -> grants/rsp_id sequence 0,1,2,3,0.
//  3 req2 a=3F800000 b=00000000 -> rsp_data=7F800000, flags=00010; rsp_ready low 10 cycles:
//    rsp held stable, req_ready all 0, busy=1.
//  4 divider stub asserts done 1 cycle after CLR (stale) then at cycle 5 -> only cycle-5
//    result captured.
//  5 DIV_TIMEOUT_EN, TMO=16, divider never done -> rsp_data=7FC00000, flags=00100, tmo_err=1.
//  6 rst pulsed during RUN -> all outputs at reset values, no rsp_valid, pointer 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions used by the divider arbiter and its sub-blocks.
//  - rounding-mode encodings driven onto the divider round-mode input
//  - canonical IEEE-754 single constants (quiet NaN, +inf, +zero)
//  - bit positions inside the 5-bit exception flag vector {ov,un,inv,div_zero,inexact}
//  - arbiter FSM state encoding
package fpu_pkg;

  // Rounding modes
  localparam logic [2:0] RM_RNE = 3'b000;  // nearest, ties to even
  localparam logic [2:0] RM_RZ  = 3'b001;  // toward zero
  localparam logic [2:0] RM_RD  = 3'b010;  // toward -inf
  localparam logic [2:0] RM_RU  = 3'b011;  // toward +inf
  localparam logic [2:0] RM_RNA = 3'b100;  // nearest, ties away

  // Single-precision constants
  localparam logic [31:0] FP_NANQ = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Flag vector bit indices
  localparam int FLG_NX = 0;  // inexact
  localparam int FLG_DZ = 1;  // divide by zero
  localparam int FLG_NV = 2;  // invalid
  localparam int FLG_UF = 3;  // underflow
  localparam int FLG_OF = 4;  // overflow

  // Arbiter FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CLR  = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Flag vector with only the invalid bit set
  function automatic logic [4:0] flags_invalid();
    logic [4:0] f;
    f = '0;
    f[FLG_NV] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant logic (purely combinational).
// The priority pointer lives in the parent so it only moves on an accepted handshake.
// Ports:
//  req        in   NREQ  request bits
//  ptr        in   IDW   index with highest priority this cycle
//  grant      out  NREQ  one-hot grant (zero when no request)
//  grant_idx  out  IDW   index of granted requester (0 when none)
//  any        out  1     at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  // cand[k] is the requester index sitting k places after the pointer (wrapping)
  logic [IDW-1:0]  cand [NREQ];
  logic [NREQ-1:0] cand_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum          = {1'b0, ptr} + (IDW+1)'(gi);
      assign cand[gi]     = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
      assign cand_vld[gi] = req[cand[gi]];
    end
  endgenerate

  // Scan from the far end so the candidate closest to the pointer wins
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_idx = cand[k];
        any       = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_oh
      assign grant[gi] = any && (grant_idx == IDW'(gi));
    end
  endgenerate

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one multi-cycle fp_div unit among NREQ requesters.
// Round-robin grant over valid/ready request channels, operand latch, divider
// restart/sequencing, and a single tagged response channel.
// Optional feature macro: DIV_TIMEOUT_EN (RUN timeout after TMO cycles, sticky tmo_err).
// Ports:
//  clk, rst                      clock, asynchronous active-high reset
//  req_valid/req_ready           per-requester request handshake
//  req_a/req_b/req_rm            packed operands and rounding modes, requester i at [i*W +: W]
//  rsp_valid/rsp_ready           response handshake
//  rsp_id/rsp_data/rsp_flags     owner index, quotient, {ov,un,inv,div_zero,inexact}
//  div_in1/div_in2/div_round_m   registered divider operands
//  div_act/div_rst_n             divider active / active-low divider reset
//  div_out/div_done/div_flags    divider result interface
//  busy                          FSM not idle
//  tmo_err                       sticky timeout indicator (0 without DIV_TIMEOUT_EN)
module fp_div_arbiter
  import fpu_pkg::*;
#(
  parameter int W        = 32,
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MIN_WAIT = 2,
  parameter int TMO      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_rm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic [4:0]        rsp_flags,
  output logic [W-1:0]      div_in1,
  output logic [W-1:0]      div_in2,
  output logic [2:0]        div_round_m,
  output logic              div_act,
  output logic              div_rst_n,
  input  logic [W-1:0]      div_out,
  input  logic              div_done,
  input  logic [4:0]        div_flags,
  output logic              busy,
  output logic              tmo_err
);

  localparam int CNT_MAX = (TMO > MIN_WAIT) ? TMO : MIN_WAIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t          state_reg, state_next;
  logic [IDW-1:0]  ptr_reg;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]    a_reg, b_reg, res_data_reg;
  logic [2:0]      rm_reg;
  logic [IDW-1:0]  id_reg;
  logic [4:0]      res_flags_reg;

  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            done_ok;
  logic            tmo_hit;

  // Unpack the per-requester buses so the grant index can select directly
  logic [W-1:0] req_a_arr  [NREQ];
  logic [W-1:0] req_b_arr  [NREQ];
  logic [2:0]   req_rm_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_a_arr[gi]  = req_a[gi*W +: W];
      assign req_b_arr[gi]  = req_b[gi*W +: W];
      assign req_rm_arr[gi] = req_rm[gi*3 +: 3];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_ok    = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      ST_IDLE: if (grant_any) state_next = ST_CLR;
      ST_CLR: begin
        cnt_next   = '0;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // done during the first MIN_WAIT cycles may still be the divider's
        // registered output from before the restart, so it is not trusted
        done_ok = div_done && (cnt_reg >= CW'(MIN_WAIT));
`ifdef DIV_TIMEOUT_EN
        tmo_hit  = !done_ok && (cnt_reg == CW'(TMO - 1));
        cnt_next = cnt_reg + CW'(1);
`else
        if (cnt_reg < CW'(MIN_WAIT)) cnt_next = cnt_reg + CW'(1);
`endif
        if (done_ok || tmo_hit) state_next = ST_RESP;
      end
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      rm_reg        <= '0;
      id_reg        <= '0;
      res_data_reg  <= '0;
      res_flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_IDLE && grant_any) begin
        a_reg   <= req_a_arr[grant_idx];
        b_reg   <= req_b_arr[grant_idx];
        rm_reg  <= req_rm_arr[grant_idx];
        id_reg  <= grant_idx;
        ptr_reg <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      if (done_ok) begin
        res_data_reg  <= div_out;
        res_flags_reg <= div_flags;
      end else if (tmo_hit) begin
        res_data_reg  <= FP_NANQ;
        res_flags_reg <= flags_invalid();
      end
    end
  end

`ifdef DIV_TIMEOUT_EN
  logic tmo_err_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tmo_err_reg <= 1'b0;
    else if (tmo_hit) tmo_err_reg <= 1'b1;
  end
  assign tmo_err = tmo_err_reg;
`else
  assign tmo_err = 1'b0;
`endif

  assign req_ready   = (state_reg == ST_IDLE) ? grant_oh : '0;
  assign rsp_valid   = (state_reg == ST_RESP);
  assign rsp_id      = id_reg;
  assign rsp_data    = res_data_reg;
  assign rsp_flags   = res_flags_reg;
  assign div_in1     = a_reg;
  assign div_in2     = b_reg;
  assign div_round_m = rm_reg;
  assign div_act     = (state_reg == ST_RUN);
  // Held low through reset and for the single CLR cycle
  assign div_rst_n   = ~rst & (state_reg != ST_CLR);
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: divider stub with programmable done delay, a
// transaction-level round-robin/latency model checked every cycle, and
// directed cases with literal expectations.
module tb_fp_div_arbiter;

  localparam int W        = 32;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int MIN_WAIT = 2;
  localparam int TMO      = 16;
  localparam int NEVER    = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ*3-1:0] req_rm = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic [4:0]        rsp_flags;
  logic [W-1:0]      div_in1, div_in2, div_out;
  logic [2:0]        div_round_m;
  logic              div_act, div_rst_n, div_done, busy, tmo_err;
  logic [4:0]        div_flags;

  fp_div_arbiter #(
    .W(W), .NREQ(NREQ), .IDW(IDW), .MIN_WAIT(MIN_WAIT), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .div_in1(div_in1), .div_in2(div_in2), .div_round_m(div_round_m),
    .div_act(div_act), .div_rst_n(div_rst_n),
    .div_out(div_out), .div_done(div_done), .div_flags(div_flags),
    .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- divider stub ----------------
  function automatic logic [31:0] stub_q(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h3F00_0000;
    if (a == 32'h3F80_0000 && b == 32'h0000_0000) return 32'h7F80_0000;
    return a ^ {b[15:0], b[31:16]} ^ {29'b0, rm};
  endfunction

  function automatic logic [4:0] stub_f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 5'b00000;
    if (a == 32'h3F80_0000 && b == 32'h0000_0000) return 5'b00010;
    return a[4:0] ^ b[9:5];
  endfunction

  int done_at   = MIN_WAIT;  // RUN cycle from which done is held high
  bit stale_en  = 1'b0;      // extra stale done pulse in the first RUN cycle
  int next_done_at = MIN_WAIT;
  bit next_stale   = 1'b0;
  int run_cyc = 0;

  always @(posedge clk) begin
    if (!div_rst_n)   run_cyc <= 0;
    else if (div_act) run_cyc <= run_cyc + 1;
  end

  assign div_done  = div_act && ((run_cyc >= done_at) || (stale_en && run_cyc == 0));
  assign div_out   = (div_act && run_cyc >= done_at) ? stub_q(div_in1, div_in2, div_round_m) : 32'hDEAD_BEEF;
  assign div_flags = (div_act && run_cyc >= done_at) ? stub_f(div_in1, div_in2) : 5'b11111;

  // ---------------- transaction model ----------------
  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int i = 0; i < NREQ; i++)
      if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return -1;
  endfunction

  bit          m_busy = 1'b0;
  int          m_ptr = 0;
  int          m_rsp_cycle = 0;
  int          m_tmo_at = NEVER;
  logic [31:0] m_a, m_b, m_data;
  logic [2:0]  m_rm;
  logic [4:0]  m_flags;
  int          m_id;

  always @(negedge clk) begin
    int g, k;
    logic [NREQ-1:0] exp_rdy;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div_act", div_act, 0);
      chk("rst_div_rst_n", div_rst_n, 0);
      chk("rst_tmo_err", tmo_err, 0);
      m_busy = 1'b0;
      m_ptr = 0;
      m_tmo_at = NEVER;
    end else begin
      chk("tmo_err", tmo_err, (cyc >= m_tmo_at) ? 1 : 0);
      if (!m_busy) begin
        g = model_grant(req_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("idle_busy", busy, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
        if (g >= 0) begin
          m_a   = req_a[g*W +: W];
          m_b   = req_b[g*W +: W];
          m_rm  = req_rm[g*3 +: 3];
          m_id  = g;
          m_ptr = (g + 1) % NREQ;
          done_at  = next_done_at;
          stale_en = next_stale;
          k = (done_at > MIN_WAIT) ? done_at : MIN_WAIT;
          m_data  = stub_q(m_a, m_b, m_rm);
          m_flags = stub_f(m_a, m_b);
`ifdef DIV_TIMEOUT_EN
          if (k > TMO - 1) begin
            k = TMO - 1;
            m_data  = 32'h7FC0_0000;
            m_flags = 5'b00100;
            if (m_tmo_at == NEVER) m_tmo_at = cyc + 3 + k;
          end
`endif
          m_rsp_cycle = cyc + 3 + k;
          m_busy = 1'b1;
        end
      end else begin
        chk("busy_req_ready", req_ready, 0);
        chk("busy", busy, 1);
        chk("div_in1", div_in1, m_a);
        chk("div_in2", div_in2, m_b);
        chk("div_round_m", div_round_m, m_rm);
        chk("rsp_valid", rsp_valid, (cyc >= m_rsp_cycle) ? 1 : 0);
        if (cyc >= m_rsp_cycle) begin
          chk("rsp_id", rsp_id, m_id);
          chk("rsp_data", rsp_data, m_data);
          chk("rsp_flags", rsp_flags, m_flags);
          if (rsp_ready) begin
            $display("txn id=%0d a=%h b=%h rm=%0d -> data=%h flags=%b cycle=%0d",
                     m_id, m_a, m_b, m_rm, rsp_data, rsp_flags, cyc);
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 99;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, output int hs_cyc);
    @(posedge clk); #1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_rm[i*3 +: 3] = rm;
    req_valid[i]     = 1'b1;
    hs_cyc = -1;
    for (int t = 0; t < 100 && hs_cyc < 0; t++) begin
      @(negedge clk);
      if (req_ready[i]) hs_cyc = cyc;
    end
    if (hs_cyc < 0) chk("grant_timeout", 0, 1);
    @(posedge clk); #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int r_cyc, output logic [31:0] d, output logic [4:0] f,
                          output logic [IDW-1:0] id);
    r_cyc = -1; d = '0; f = '0; id = '0;
    for (int t = 0; t < 200 && r_cyc < 0; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        r_cyc = cyc; d = rsp_data; f = rsp_flags; id = rsp_id;
      end
    end
    if (r_cyc < 0) chk("rsp_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs, rc;
    logic [31:0] d;
    logic [4:0] f;
    logic [IDW-1:0] id;
    int grants[$];
    int rids[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    bit seen;

    do_reset();
    @(negedge clk);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_div_in1", div_in1, 0);

    // 1: 1.0 / 2.0 from requester 0
    issue(0, 32'h3F80_0000, 32'h4000_0000, 3'b000, hs);
    wait_rsp(rc, d, f, id);
    chk("t1_id", id, 0);
    chk("t1_data", d, 32'h3F00_0000);
    chk("t1_flags", f, 5'b00000);
    chk("t1_latency", rc - hs - 1, 1 + MIN_WAIT + 1);
    repeat (2) @(posedge clk);

    // 2: all requesters valid from pointer 0
    do_reset();
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = $urandom;
      req_b[i*W +: W] = $urandom;
      req_rm[i*3 +: 3] = 3'(i);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 300 && rids.size() < 5; t++) begin
      @(negedge clk);
      if (req_ready != 0) grants.push_back(oh_idx(req_ready));
      if (rsp_valid && rsp_ready) rids.push_back(int'(rsp_id));
    end
    @(posedge clk); #1 req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_grant", (k < grants.size()) ? grants[k] : 99, exp_seq[k]);
      chk("t2_rsp_id", (k < rids.size()) ? rids[k] : 99, exp_seq[k]);
    end
    repeat (2) @(posedge clk);

    // 3: 1.0 / 0.0 from requester 2, response back-pressured
    #1 rsp_ready = 1'b0;
    issue(2, 32'h3F80_0000, 32'h0000_0000, 3'b000, hs);
    wait_rsp(rc, d, f, id);
    chk("t3_id", id, 2);
    chk("t3_data", d, 32'h7F80_0000);
    chk("t3_flags", f, 5'b00010);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1 req_valid = 4'b1011;
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_data", rsp_data, 32'h7F80_0000);
      chk("t3_hold_ready", req_ready, 0);
      chk("t3_hold_busy", busy, 1);
    end
    @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    // 4: stale done in first RUN cycle, real done at RUN cycle 5
    next_done_at = 5; next_stale = 1'b1;
    issue(1, 32'h3F80_0000, 32'h4000_0000, 3'b001, hs);
    wait_rsp(rc, d, f, id);
    chk("t4_data", d, 32'h3F00_0000);
    chk("t4_flags", f, 5'b00000);
    chk("t4_latency", rc - hs - 1, 7);
    next_done_at = MIN_WAIT; next_stale = 1'b0;
    repeat (2) @(posedge clk);

    // 6: reset while the divider is running
    next_done_at = 7;
    issue(1, 32'h1234_5678, 32'h4000_0000, 3'b000, hs);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (div_act) seen = 1'b1;
    end
    chk("t6_reached_run", seen, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_div_rst_n", div_rst_n, 0);
    chk("t6_rsp_data", rsp_data, 0);
    @(posedge clk); #1 rst = 1'b0; next_done_at = MIN_WAIT;
    req_valid = '1;
    @(negedge clk);
    chk("t6_ptr0_grant", oh_idx(req_ready), 0);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(rc, d, f, id);
    chk("t6_next_id", id, 0);
    repeat (2) @(posedge clk);

    // Random traffic
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*W +: W]  = $urandom;
        req_b[i*W +: W]  = $urandom;
        req_rm[i*3 +: 3] = 3'($urandom_range(0, 4));
      end
      rsp_ready    = ($urandom_range(0, 3) != 0);
      next_done_at = $urandom_range(0, 7);
      next_stale   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1;
    repeat (30) @(posedge clk);

`ifdef DIV_TIMEOUT_EN
    // 5: divider never completes
    do_reset();
    next_done_at = NEVER;
    issue(3, 32'h4040_0000, 32'h4000_0000, 3'b000, hs);
    wait_rsp(rc, d, f, id);
    chk("t5_data", d, 32'h7FC0_0000);
    chk("t5_flags", f, 5'b00100);
    chk("t5_id", id, 3);
    chk("t5_latency", rc - hs - 1, 1 + TMO);
    @(negedge clk);
    chk("t5_tmo_err", tmo_err, 1);
    next_done_at = MIN_WAIT;
    repeat (3) @(posedge clk);
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
